// File: rtl/wb_pipe_bridge_master.sv
// wb_pipe_bridge_master
//   Bridges the Ibex LSU data port onto a Wishbone B4 pipelined master port.
//   Up to MAX_OUTST requests may be accepted before any is acknowledged.
//   Responses come back to the core registered, one cycle after the bus
//   ack/err, in issue order.
//
//   Optional feature: define WB_BRIDGE_TIMEOUT_EN to build in a watchdog.
//   The watchdog aborts a cycle that has had no ack/err for TIMEOUT_CYCLES
//   cycles. It then returns an error response for every outstanding transfer.
//   Without the macro there is no watchdog and timeout_o is tied low.
//
// Ports
//   clk_i, reset_ni            clock, asynchronous active-low reset
//   data_req_i .. data_err_o   Ibex data-side request/response interface
//   data_wdata_intg_i          unused; data_rdata_intg_o tied 0
//   mcyc_o .. msel_o           Wishbone master request outputs
//   mstall_i, mack_i, merr_i   Wishbone flow control and termination
//   mdata_i                    Wishbone read data
//   spurious_o                 sticky flag: ack/err seen with nothing outstanding
//   timeout_o                  one-cycle pulse when the watchdog aborts

module wb_pipe_bridge_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_OUTST      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [6:0]              data_wdata_intg_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic [6:0]              data_rdata_intg_o,
  output logic                    data_err_o,
  output logic                    mcyc_o,
  output logic                    mstb_o,
  output logic                    mwe_o,
  output logic [ADDR_WIDTH-1:0]   maddr_o,
  output logic [DATA_WIDTH-1:0]   mdata_o,
  output logic [DATA_WIDTH/8-1:0] msel_o,
  input  logic                    mstall_i,
  input  logic                    mack_i,
  input  logic                    merr_i,
  input  logic [DATA_WIDTH-1:0]   mdata_i,
  output logic                    spurious_o,
  output logic                    timeout_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;

  state_t        state;
  logic [CW-1:0] outst;
  logic [CW-1:0] outst_next;
  logic          busy;
  logic          not_full;
  logic          bus_resp;
  logic          resp_take;
  logic          drain;
  logic          dec;
  logic          unused_in;

  assign unused_in = ^data_wdata_intg_i;

  // Request fields go straight to the bus. A stalled strobe therefore stays
  // stable only because the core holds its request until it is granted.
  assign busy       = (outst != '0);
  assign not_full   = (outst < MAX_CNT);
  assign mstb_o     = data_req_i & not_full & (state != ABORT);
  assign data_gnt_o = mstb_o & ~mstall_i;
  assign mcyc_o     = (mstb_o | busy) & (state != ABORT);
  assign mwe_o      = data_we_i;
  assign maddr_o    = data_addr_i;
  assign mdata_o    = data_wdata_i;
  assign msel_o     = data_be_i;

  assign data_rdata_intg_o = '0;

  // A bus termination counts when something is outstanding. It also counts
  // when it lands in the same cycle as the grant it answers.
  // Terminations are ignored while aborting.
  assign bus_resp  = (mack_i | merr_i) & (state != ABORT);
  assign resp_take = bus_resp & (busy | data_gnt_o);
  assign drain     = (state == ABORT) & busy;
  assign dec       = resp_take | drain;

  // A grant and a retirement in the same cycle leave the count unchanged.
  always_comb begin
    outst_next = outst;
    if (data_gnt_o && !dec) begin
      outst_next = outst + ONE;
    end else if (!data_gnt_o && dec) begin
      outst_next = outst - ONE;
    end
  end

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_o      = 1'b0;
`endif

  // Control FSM, outstanding counter and the registered response path.
  // When both ack and err arrive together, err wins.
  // An abort drain produces one error response per cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state         <= IDLE;
      outst         <= '0;
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      data_rdata_o  <= '0;
      spurious_o    <= 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
      wd            <= '0;
      timeout_o     <= 1'b0;
`endif
    end else begin
      outst         <= outst_next;
      data_rvalid_o <= dec;

      if (resp_take) begin
        data_err_o   <= merr_i;
        data_rdata_o <= merr_i ? '0 : mdata_i;
      end else if (drain) begin
        data_err_o   <= 1'b1;
        data_rdata_o <= '0;
      end else begin
        data_err_o   <= 1'b0;
      end

      if (bus_resp && !busy && !data_gnt_o) begin
        spurious_o <= 1'b1;
      end

      case (state)
        IDLE, ACTIVE: state <= (outst_next != '0) ? ACTIVE : IDLE;
        ABORT:        if (outst_next == '0) state <= IDLE;
        default:      state <= IDLE;
      endcase

`ifdef WB_BRIDGE_TIMEOUT_EN
      // The watchdog only counts quiet ACTIVE cycles. Being in IDLE (and so a
      // grant from IDLE) or any termination restarts it.
      timeout_o <= 1'b0;
      if (state == ACTIVE) begin
        if (bus_resp) begin
          wd <= '0;
        end else if (wd == WD_LIMIT) begin
          wd        <= '0;
          timeout_o <= 1'b1;
          state     <= ABORT;
        end else begin
          wd <= wd + 1'b1;
        end
      end else begin
        wd <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wb_pipe_bridge_master.sv
// tb_wb_pipe_bridge_master
//   Directed bench for wb_pipe_bridge_master. The Wishbone slave side is
//   driven by hand. Expected values are written as literals next to each step.
//   Inputs change 1 time unit after the rising edge, and outputs are sampled
//   then, well away from the next edge.

module tb_wb_pipe_bridge_master;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [6:0]  data_wdata_intg;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic [6:0]  data_rdata_intg;
  logic        data_err;
  logic        mcyc;
  logic        mstb;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mdata_out;
  logic [3:0]  msel;
  logic        mstall;
  logic        mack;
  logic        merr;
  logic [31:0] mdata_in;
  logic        spurious;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_pipe_bridge_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTST(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_we_i(data_we),
    .data_be_i(data_be), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_wdata_intg_i(data_wdata_intg), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_rdata_intg_o(data_rdata_intg),
    .data_err_o(data_err), .mcyc_o(mcyc), .mstb_o(mstb), .mwe_o(mwe),
    .maddr_o(maddr), .mdata_o(mdata_out), .msel_o(msel), .mstall_i(mstall),
    .mack_i(mack), .merr_i(merr), .mdata_i(mdata_in),
    .spurious_o(spurious), .timeout_o(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic req, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
    data_req   = req;
    data_we    = we;
    data_addr  = addr;
    data_wdata = wdata;
    data_be    = 4'hF;
  endtask

  initial begin
    int n;
    reset_ni = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    data_wdata_intg = '0;
    mstall = 1'b0; mack = 1'b0; merr = 1'b0; mdata_in = '0;
    #12;
    $display("[TB] reset state");
    check_output("rst_rvalid", data_rvalid, 1'b0);
    check_output("rst_err", data_err, 1'b0);
    check_output("rst_rdata", data_rdata, 32'h0);
    check_output("rst_spurious", spurious, 1'b0);
    check_output("rst_timeout", timeout, 1'b0);
    check_output("rst_mcyc", mcyc, 1'b0);
    check_output("rst_mstb", mstb, 1'b0);
    check_output("rst_intg", data_rdata_intg, 7'h0);
    tick();
    reset_ni = 1'b1;
    tick();

    $display("[TB] single read");
    apply_stimulus(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    check_output("t1_gnt", data_gnt, 1'b1);
    check_output("t1_mstb", mstb, 1'b1);
    check_output("t1_maddr", maddr, 32'h100);
    check_output("t1_mwe", mwe, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_output("t1_mcyc_held", mcyc, 1'b1);
    check_output("t1_mstb_off", mstb, 1'b0);
    tick();
    mack = 1'b1; mdata_in = 32'hDEADBEEF;
    #1;
    check_output("t1_no_rvalid_yet", data_rvalid, 1'b0);
    tick();
    mack = 1'b0; mdata_in = 32'h0;
    check_output("t1_rvalid", data_rvalid, 1'b1);
    check_output("t1_rdata", data_rdata, 32'hDEADBEEF);
    check_output("t1_err", data_err, 1'b0);
    #1;
    check_output("t1_mcyc_idle", mcyc, 1'b0);
    tick();
    check_output("t1_rvalid_pulse", data_rvalid, 1'b0);

    $display("[TB] four writes fill the window");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i));
      #1;
      check_output($sformatf("t2_gnt%0d", i), data_gnt, 1'b1);
      check_output($sformatf("t2_mdata%0d", i), mdata_out, 32'hA000 + 32'(i));
      tick();
    end
    apply_stimulus(1'b1, 1'b1, 32'h210, 32'hA004);
    #1;
    check_output("t2_full_gnt", data_gnt, 1'b0);
    check_output("t2_full_mstb", mstb, 1'b0);
    check_output("t2_full_mcyc", mcyc, 1'b1);
    tick();
    check_output("t2_full_gnt2", data_gnt, 1'b0);
    mack = 1'b1;
    #1;
    check_output("t2_ack_cycle_gnt", data_gnt, 1'b0);
    tick();
    mack = 1'b0;
    #1;
    check_output("t2_slot_freed_gnt", data_gnt, 1'b1);
    check_output("t2_rvalid", data_rvalid, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    mack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    mack = 1'b0;
    #1;
    check_output("t2_last_rvalid", data_rvalid, 1'b1);
    check_output("t2_drained_mcyc", mcyc, 1'b0);
    check_output("t2_no_spurious", spurious, 1'b0);
    tick();

    $display("[TB] stalled strobe");
    mstall = 1'b1;
    apply_stimulus(1'b1, 1'b0, 32'h300, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output($sformatf("t3_stall_mstb%0d", i), mstb, 1'b1);
      check_output($sformatf("t3_stall_gnt%0d", i), data_gnt, 1'b0);
      check_output($sformatf("t3_stall_addr%0d", i), maddr, 32'h300);
      tick();
    end
    mstall = 1'b0;
    #1;
    check_output("t3_gnt", data_gnt, 1'b1);
    check_output("t3_addr", maddr, 32'h300);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    mack = 1'b1; mdata_in = 32'h0BAD_F00D;
    tick();
    mack = 1'b0;
    check_output("t3_rdata", data_rdata, 32'h0BAD_F00D);
    tick();

    $display("[TB] error then data, in order");
    apply_stimulus(1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    apply_stimulus(1'b1, 1'b0, 32'h404, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    merr = 1'b1;
    tick();
    merr = 1'b0; mack = 1'b1; mdata_in = 32'h1234;
    check_output("t4_rvalid1", data_rvalid, 1'b1);
    check_output("t4_err1", data_err, 1'b1);
    tick();
    mack = 1'b0;
    check_output("t4_rvalid2", data_rvalid, 1'b1);
    check_output("t4_err2", data_err, 1'b0);
    check_output("t4_rdata2", data_rdata, 32'h1234);
    #1;
    check_output("t4_mcyc_idle", mcyc, 1'b0);
    tick();

    $display("[TB] spurious ack");
    mack = 1'b1;
    tick();
    mack = 1'b0;
    check_output("t5_no_rvalid", data_rvalid, 1'b0);
    check_output("t5_spurious", spurious, 1'b1);
    tick();
    tick();
    check_output("t5_sticky", spurious, 1'b1);
    reset_ni = 1'b0;
    #1;
    check_output("t5_cleared", spurious, 1'b0);
    tick();
    reset_ni = 1'b1;
    tick();

    $display("[TB] reset mid-transfer");
    apply_stimulus(1'b1, 1'b0, 32'h500, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_output("t7_inflight_mcyc", mcyc, 1'b1);
    reset_ni = 1'b0;
    #1;
    check_output("t7_reset_mcyc", mcyc, 1'b0);
    tick();
    reset_ni = 1'b1;
    mack = 1'b1;
    tick();
    mack = 1'b0;
    check_output("t7_dropped_rvalid", data_rvalid, 1'b0);
    reset_ni = 1'b0;
    tick();
    reset_ni = 1'b1;
    tick();

    $display("[TB] hung transfer");
    apply_stimulus(1'b1, 1'b0, 32'h600, 32'h0);
    tick();
    apply_stimulus(1'b1, 1'b0, 32'h604, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
`ifdef WB_BRIDGE_TIMEOUT_EN
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_output("t6_timeout_cycle", 64'(n), 64'd15);
    check_output("t6_mcyc_abort", mcyc, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h700, 32'h0);
    #1;
    check_output("t6_abort_gnt", data_gnt, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    mack = 1'b1;
    tick();
    mack = 1'b0;
    check_output("t6_rvalid1", data_rvalid, 1'b1);
    check_output("t6_err1", data_err, 1'b1);
    check_output("t6_timeout_pulse", timeout, 1'b0);
    tick();
    check_output("t6_rvalid2", data_rvalid, 1'b1);
    check_output("t6_err2", data_err, 1'b1);
    tick();
    check_output("t6_done_rvalid", data_rvalid, 1'b0);
    check_output("t6_late_ack_ignored", spurious, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h700, 32'h0);
    #1;
    check_output("t6_idle_gnt", data_gnt, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    mack = 1'b1;
    tick();
    mack = 1'b0;
    tick();
`else
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (timeout === 1'b1) n++;
      tick();
    end
    check_output("t6_no_timeout", 64'(n), 64'd0);
    check_output("t6_still_mcyc", mcyc, 1'b1);
    mack = 1'b1;
    tick();
    tick();
    mack = 1'b0;
    check_output("t6_late_rvalid", data_rvalid, 1'b1);
    check_output("t6_late_err", data_err, 1'b0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
